// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon permutation controller.
// Holds the FSM encoding, round-constant rule and word rotation.
package ascon_pkg;

    localparam int W          = 64;
    localparam int MAX_ROUNDS = 12;

    typedef logic [W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    // c_i = ((15 - i) << 4) | i
    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'(4'd15 - i), i};
    endfunction

    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant add, bit-sliced S-box,
// then the linear diffusion layer.
module ascon_linear
    import ascon_pkg::*;
(
    input  word_t x0,
    input  word_t x1,
    input  word_t x2,
    input  word_t x3,
    input  word_t x4,
    output word_t y0,
    output word_t y1,
    output word_t y2,
    output word_t y3,
    output word_t y4
);

    assign y0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    assign y1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    assign y2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    assign y3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    assign y4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);

endmodule

module ascon_round
    import ascon_pkg::*;
(
    input  word_t       x0,
    input  word_t       x1,
    input  word_t       x2,
    input  word_t       x3,
    input  word_t       x4,
    input  logic [3:0]  i,
    output word_t       y0,
    output word_t       y1,
    output word_t       y2,
    output word_t       y3,
    output word_t       y4
);

    word_t s0, s1, s2, s3, s4;
    word_t t0, t1, t2, t3, t4;
    word_t u0, u1, u2, u3, u4;
    word_t a0, a1, a2, a3, a4;

    assign s0 = x0 ^ x4;
    assign s1 = x1;
    assign s2 = x2 ^ {56'd0, round_const(i)} ^ x1;
    assign s3 = x3;
    assign s4 = x4 ^ x3;

    // chi-like core of the S-box
    assign t0 = ~s0 & s1;
    assign t1 = ~s1 & s2;
    assign t2 = ~s2 & s3;
    assign t3 = ~s3 & s4;
    assign t4 = ~s4 & s0;

    assign u0 = s0 ^ t1;
    assign u1 = s1 ^ t2;
    assign u2 = s2 ^ t3;
    assign u3 = s3 ^ t4;
    assign u4 = s4 ^ t0;

    assign a0 = u0 ^ u4;
    assign a1 = u1 ^ u0;
    assign a2 = ~u2;
    assign a3 = u3 ^ u2;
    assign a4 = u4;

    ascon_linear u_lin (
        .x0 (a0),
        .x1 (a1),
        .x2 (a2),
        .x3 (a3),
        .x4 (a4),
        .y0 (y0),
        .y1 (y1),
        .y2 (y2),
        .y3 (y3),
        .y4 (y4)
    );

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative p^a controller: one round per clock, shared round datapath,
// valid/ready on both the request and result sides.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int DEFAULT_ROUNDS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rounds,
    input  logic [63:0] x0_in,
    input  logic [63:0] x1_in,
    input  logic [63:0] x2_in,
    input  logic [63:0] x3_in,
    input  logic [63:0] x4_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] x0_out,
    output logic [63:0] x1_out,
    output logic [63:0] x2_out,
    output logic [63:0] x3_out,
    output logic [63:0] x4_out,
    output logic        busy
);

    fsm_t        fsm;
    logic [3:0]  idx;
    word_t       s0, s1, s2, s3, s4;
    word_t       r0, r1, r2, r3, r4;
    logic [3:0]  eff_r;
    logic        accept;

    assign eff_r = (rounds >= 4'd1 && rounds <= 4'(MAX_ROUNDS))
                 ? rounds : 4'(DEFAULT_ROUNDS);

    // out_ready feeds in_ready so a new request can overlap the drain
    assign in_ready  = ~rst & ((fsm == S_IDLE)
                     | ((fsm == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (fsm == S_DONE);
    assign busy      = (fsm == S_RUN);

    assign x0_out = s0;
    assign x1_out = s1;
    assign x2_out = s2;
    assign x3_out = s3;
    assign x4_out = s4;

    ascon_round u_round (
        .x0 (s0),
        .x1 (s1),
        .x2 (s2),
        .x3 (s3),
        .x4 (s4),
        .i  (idx),
        .y0 (r0),
        .y1 (r1),
        .y2 (r2),
        .y3 (r3),
        .y4 (r4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= S_IDLE;
            idx <= '0;
            s0  <= '0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            s4  <= '0;
        end else begin
            unique case (fsm)
                S_RUN: begin
                    s0 <= r0;
                    s1 <= r1;
                    s2 <= r2;
                    s3 <= r3;
                    s4 <= r4;
                    if (idx == 4'(MAX_ROUNDS - 1))
                        fsm <= S_DONE;
                    else
                        idx <= idx + 4'd1;
                end
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        s0  <= x0_in;
                        s1  <= x1_in;
                        s2  <= x2_in;
                        s3  <= x3_in;
                        s4  <= x4_in;
                        idx <= 4'(MAX_ROUNDS) - eff_r;
                        fsm <= S_RUN;
                    end else if (fsm == S_DONE && out_ready) begin
                        fsm <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule
